// File: rtl/alu_sequencer_if.sv
// Request/response handshake bundle for the ALU sequencer.
// The requester holds the master modport; the sequencer holds the slave modport.
interface alu_sequencer_if #(
    parameter int N = 4
);
    // request channel
    logic         req_valid;
    logic         req_ready;
    logic [3:0]   req_op;
    logic [N-1:0] req_a;
    logic [N-1:0] req_b;
    logic         req_use_acc;

    // response channel
    logic         rsp_valid;
    logic         rsp_ready;
    logic [N-1:0] rsp_result;
    logic [3:0]   rsp_flags;
    logic         rsp_err;

    modport master (
        output req_valid, req_op, req_a, req_b, req_use_acc, rsp_ready,
        input  req_ready, rsp_valid, rsp_result, rsp_flags, rsp_err
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b, req_use_acc, rsp_ready,
        output req_ready, rsp_valid, rsp_result, rsp_flags, rsp_err
    );
endinterface

// File: rtl/alu_sequencer.sv
// ALU sequencer: accepts one request, presents its operands to an external
// combinational ALU for one cycle, captures result and flags, then holds the
// response until it is consumed. Keeps an accumulator of the last legal
// result and a saturating count of completed legal operations.
module alu_sequencer #(
    parameter int N = 4
) (
    input  logic                clk,
    input  logic                rst,
    alu_sequencer_if.slave      bus,
    output logic [N-1:0]        alu_a,
    output logic [N-1:0]        alu_b,
    output logic [3:0]          alu_ctrl,
    input  logic [N-1:0]        alu_result,
    input  logic                alu_z,
    input  logic                alu_n,
    input  logic                alu_v,
    input  logic                alu_c,
    output logic [N-1:0]        acc,
    output logic [7:0]          op_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef struct packed {
        logic [N-1:0] result;
        logic [3:0]   flags;
        logic         err;
    } rsp_t;

    state_t       state_q, state_d;
    logic [3:0]   op_q;
    logic [N-1:0] a_q;
    logic [N-1:0] b_q;
    rsp_t         rsp_q;
    logic [N-1:0] acc_q;
    logic [7:0]   cnt_q;

    logic         xfer;
    logic         op_legal;

    // Opcodes with the top bit set are illegal and never touch the ALU.
    assign op_legal = ~op_q[3];
    assign xfer     = (state_q == IDLE) && bus.req_valid;

    // Next-state and handshake outputs; ready only in IDLE, valid only in RESP.
    always_comb begin
        state_d       = state_q;
        bus.req_ready = 1'b0;
        bus.rsp_valid = 1'b0;
        case (state_q)
            IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) state_d = EXEC;
            end
            EXEC: begin
                state_d = RESP;
            end
            RESP: begin
                bus.rsp_valid = 1'b1;
                if (bus.rsp_ready) state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Operand latch; operand A comes from the accumulator value of the accept cycle when asked.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q <= 4'h0;
            a_q  <= '0;
            b_q  <= '0;
        end else if (xfer) begin
            op_q <= bus.req_op;
            a_q  <= bus.req_use_acc ? acc_q : bus.req_a;
            b_q  <= bus.req_b;
        end
    end

    // End of EXEC: capture the ALU outcome (or an error response) and update acc/count.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_q <= '0;
            acc_q <= '0;
            cnt_q <= 8'h00;
        end else if (state_q == EXEC) begin
            if (op_legal) begin
                rsp_q.result <= alu_result;
                rsp_q.flags  <= {alu_z, alu_n, alu_v, alu_c};
                rsp_q.err    <= 1'b0;
                acc_q        <= alu_result;
                if (cnt_q != 8'hFF) cnt_q <= cnt_q + 8'h01;
            end else begin
                rsp_q.result <= '0;
                rsp_q.flags  <= 4'h0;
                rsp_q.err    <= 1'b1;
            end
        end
    end

    // ALU drive comes straight from the operand registers, so it holds outside EXEC.
    assign alu_a      = a_q;
    assign alu_b      = b_q;
    assign alu_ctrl   = op_q;

    assign bus.rsp_result = rsp_q.result;
    assign bus.rsp_flags  = rsp_q.flags;
    assign bus.rsp_err    = rsp_q.err;

    assign acc      = acc_q;
    assign op_count = cnt_q;

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 Parameter N, default 4, operand/result width in bits (N >= 2).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 req_valid  input  1  request present.
REQ-005 req_ready  output  1  sequencer can accept a request.
REQ-006 req_op  input  4  ALU control code for the request.
REQ-007 req_a, req_b  input  N each  request operands.
REQ-008 req_use_acc  input  1  1 = take operand A from accumulator instead of req_a.
REQ-009 alu_a, alu_b  output  N each  operands driven to the ALU.
REQ-010 alu_ctrl  output  4  ALU control code driven to the ALU.
REQ-011 alu_result  input  N  ALU result, combinational from alu_a/alu_b/alu_ctrl.
REQ-012 alu_z, alu_n, alu_v, alu_c  input  1 each  ALU flags.
REQ-013 rsp_valid  output  1  response present.
REQ-014 rsp_ready  input  1  consumer accepts the response.
REQ-015 rsp_result  output  N  captured result.
REQ-016 rsp_flags  output  4  captured flags {Z,N,V,C}, Z in bit 3.
REQ-017 rsp_err  output  1  response is for an illegal opcode.
REQ-018 acc  output  N  accumulator, last legal result.
REQ-019 op_count  output  8  count of completed legal operations.

Function
REQ-020 FSM states: IDLE, EXEC, RESP. No other states.
REQ-021 req_ready SHALL be 1 only in IDLE; a transfer occurs when req_valid && req_ready.
REQ-022 IDLE + transfer: latch req_op, operand A (acc if req_use_acc, else req_a) and req_b into operand registers; go to EXEC.
REQ-023 alu_a, alu_b and alu_ctrl SHALL be driven from the operand registers at all times; they hold their values outside EXEC.
REQ-024 EXEC is always exactly one cycle. At its end, it SHALL capture alu_result and {alu_z,alu_n,alu_v,alu_c} into the response registers; it then goes to RESP.
REQ-025 Legal opcodes are 4'h0-4'h7. Opcodes 4'h8-4'hF are illegal: the ALU inputs are not sampled, rsp_result=0, rsp_flags=0, rsp_err=1; acc and op_count are unchanged.
REQ-026 Legal op at end of EXEC: acc <= alu_result; op_count increments, saturating at 8'hFF; rsp_err=0.
REQ-027 In RESP, rsp_valid=1. rsp_result/rsp_flags/rsp_err SHALL stay stable until rsp_ready=1; then go to IDLE.
REQ-028 rsp_valid SHALL be 0 in IDLE and EXEC.
REQ-029 Latency: request accepted in cycle t -> rsp_valid=1 in cycle t+2. Minimum spacing between accepted requests is 3 cycles.
REQ-030 req_use_acc samples acc as it is in the accept cycle (previous legal result).
REQ-031 The request inputs are ignored outside IDLE. A request held valid across RESP is accepted in the first IDLE cycle.
REQ-032 Width: the result is exactly N bits. The sequencer performs no arithmetic on data; it only increments op_count.

Reset
REQ-033 rst=1 at a clock edge: state=IDLE; operand, response, acc and op_count registers=0. Outputs are then req_ready=1, rsp_valid=0, rsp_err=0, alu_a=alu_b=0, alu_ctrl=0.
REQ-034 Reset in EXEC or RESP SHALL discard the operation in flight; no response is produced and acc is not updated.
REQ-035 rst has priority over every other input in the same cycle.

Verification
REQ-036 N=4, reset, then request op=1, a=3, b=5; the bench ALU returns result E with N=1 -> during EXEC alu_a=3, alu_b=5, alu_ctrl=1; at t+2 rsp_result=E, rsp_flags=4'b0100, rsp_err=0; after accept acc=E, op_count=1.
REQ-037 Request with req_use_acc=1 after acc=E, b=1 -> alu_a=E; the ALU returns 0 with Z=1,C=1 -> rsp_flags=4'b1001, acc=0.
REQ-038 op=4'hA -> rsp_err=1, rsp_result=0, rsp_flags=0; acc and op_count unchanged.
REQ-039 rsp_ready held 0 for 5 cycles in RESP -> response stable, req_ready=0 throughout; rsp_ready=1 -> IDLE next cycle.
REQ-040 rst asserted during EXEC -> no rsp_valid, acc and op_count=0, req_ready=1 the next cycle.
REQ-041 256+ legal ops back-to-back with req_valid held 1 -> op_count saturates at FF; each accept is exactly 3 cycles apart when rsp_ready=1.
